// File: rtl/approx_mon_pkg.sv
// Shared types and constants for the approximate-adder error monitor.
// Campaign FSM states, drain length and a counter width check.
package approx_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DRAIN_CYC = 2;

  function automatic bit cnt_w_fits(
    input int     cnt_w,
    input longint n
  );
    return (n >= 1) && (cnt_w < 63) &&
           (n < (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/approx_err_calc.sv
// First pipeline stage: exact sum, absolute error against the
// approximate sum, mismatch flag and stage-valid register.
module approx_err_calc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         acc,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W:0]   in_approx,
  output logic [W:0]   abs_err,
  output logic         mism,
  output logic         v1
);

  logic [W:0] exact;
  logic [W:0] abs_nxt;

  // Ordering the operands keeps the difference non-negative in W+1 bits.
  always_comb begin
    exact = {1'b0, in_a} + {1'b0, in_b};
    if (exact >= in_approx) abs_nxt = exact - in_approx;
    else                    abs_nxt = in_approx - exact;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_err <= '0;
      mism    <= 1'b0;
      v1      <= 1'b0;
    end else begin
      v1 <= acc;
      if (acc) begin
        abs_err <= abs_nxt;
        mism    <= (abs_nxt != '0);
      end
    end
  end

endmodule

// File: rtl/approx_err_monitor.sv
// Error-statistics monitor for an approximate adder: campaign FSM,
// sample counter and saturating second-stage accumulators.
module approx_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int W         = 8,
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17,
  parameter int ACC_W     = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_approx,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_abs,
  output logic [ACC_W-1:0] sum_sq,
  output logic [W:0]       wce,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] smp_cnt
);

  localparam int SQ_W = 2 * W + 2;
  localparam int AW   = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

  localparam logic [CNT_W-1:0] N_C  = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] N_M1 = CNT_W'(N_SAMPLES - 1);
  localparam logic [AW-1:0]    AMAX = AW'({ACC_W{1'b1}});

  if (!cnt_w_fits(CNT_W, longint'(N_SAMPLES))) begin : g_bad_cnt_w
    $error("CNT_W cannot hold N_SAMPLES");
  end

  state_t     state, state_nxt;
  logic [1:0] drain_cnt;
  logic       drain_last;
  logic       accept;
  logic       last_acc;
  logic       clr;

  logic [W:0]      abs_err;
  logic            mism;
  logic            v1;
  logic [SQ_W-1:0] sq;
  logic [AW-1:0]   abs_sum;
  logic [AW-1:0]   sq_sum;
  logic [ACC_W-1:0] abs_nxt;
  logic [ACC_W-1:0] sq_nxt;

  assign in_ready   = (state == RUN) && (smp_cnt < N_C);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_acc   = accept && (smp_cnt == N_M1);
  assign drain_last = (drain_cnt == 2'(DRAIN_CYC - 1));
  assign clr        = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (last_acc) state_nxt = DRAIN;
      DRAIN:      if (drain_last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  approx_err_calc #(
    .W(W)
  ) u_calc (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc      (accept),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_approx(in_approx),
    .abs_err  (abs_err),
    .mism     (mism),
    .v1       (v1)
  );

  // Sums are formed one bit wider than either operand so overflow is visible.
  always_comb begin
    sq = {{(W + 1){1'b0}}, abs_err} * {{(W + 1){1'b0}}, abs_err};
    abs_sum = AW'(sum_abs) + AW'(abs_err);
    sq_sum  = AW'(sum_sq) + AW'(sq);
    abs_nxt = (abs_sum > AMAX) ? AMAX[ACC_W-1:0] : abs_sum[ACC_W-1:0];
    sq_nxt  = (sq_sum > AMAX) ? AMAX[ACC_W-1:0] : sq_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_abs <= '0;
      sum_sq  <= '0;
      wce     <= '0;
      err_cnt <= '0;
      smp_cnt <= '0;
    end else if (clr) begin
      sum_abs <= '0;
      sum_sq  <= '0;
      wce     <= '0;
      err_cnt <= '0;
      smp_cnt <= '0;
    end else begin
      if (accept) smp_cnt <= smp_cnt + 1'b1;
      if (v1) begin
        sum_abs <= abs_nxt;
        sum_sq  <= sq_nxt;
        if (abs_err > wce) wce <= abs_err;
        err_cnt <= err_cnt + CNT_W'(mism);
      end
    end
  end

endmodule
